// File: rtl/cpu_axi_bridge_pkg.sv
// Shared definitions for the CPU SRAM-to-AXI3 bridge: FSM encodings, owner tags
// and the fixed AXI field values used for single-beat transfers.
package cpu_axi_bridge_pkg;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2, R_RESP = 2'd3} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_B = 2'd2, W_RESP = 2'd3} wr_state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0000;
    localparam logic [2:0] AXI_PROT  = 3'b000;

    function automatic logic [3:0] axi_id(input logic owner);
        return {3'b000, owner};
    endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// CPU-side SRAM ports and AXI3 master channels of the bridge; the master modport
// is the bridge's view, the slave modport is the view of the CPU/crossbar side.
interface cpu_axi_bridge_if;

    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_addr_ok_addr, inst_sram_rdata;

    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_addr_ok_addr, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_addr_ok_addr, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU instruction and data SRAM-like ports onto one AXI3 master,
// one read and one write in flight, data reads ahead of instruction fetch.
//
// state  | meaning
// R_IDLE | no read outstanding, may accept a read
// R_AR   | presenting read address, waiting for arready
// R_R    | waiting for rvalid, rdata captured on handshake
// R_RESP | owner's data_ok pulse with captured rdata
// W_IDLE | no write outstanding, may accept a write
// W_SEND | aw and w channels offered, each retires on its own handshake
// W_B    | waiting for bvalid
// W_RESP | data_sram_data_ok pulse
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    cpu_axi_bridge_if.master bus
);

    rd_state_t   r_state, r_next;
    wr_state_t   w_state, w_next;
    logic        inst_busy, data_busy;
    logic [31:0] rd_addr, rd_data;
    logic [1:0]  rd_size;
    logic        rd_owner;
    logic [31:0] wr_addr, wr_data;
    logic [1:0]  wr_size;
    logic [3:0]  wr_strb;
    logic        aw_done, w_done;
    logic        data_rd_pending, inst_accept, data_accept, rd_start, wr_start;
    logic        unused_inputs;

    assign unused_inputs = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                             bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

    // Reads wait for W_IDLE so a load can never overtake an earlier store.
    assign data_rd_pending = bus.data_sram_req & ~bus.data_sram_wr & ~data_busy;
    assign data_accept = resetn & bus.data_sram_req & ~data_busy & (w_state == W_IDLE)
                       & (bus.data_sram_wr | (r_state == R_IDLE));
    assign inst_accept = resetn & bus.inst_sram_req & ~inst_busy & (r_state == R_IDLE)
                       & (w_state == W_IDLE) & ~data_rd_pending;
    assign rd_start = inst_accept | (data_accept & ~bus.data_sram_wr);
    assign wr_start = data_accept & bus.data_sram_wr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rd_start)   r_next = R_AR;
            R_AR:    if (bus.arready) r_next = R_R;
            R_R:     if (bus.rvalid)  r_next = R_RESP;
            R_RESP:  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (wr_start) w_next = W_SEND;
            W_SEND:  if ((aw_done | bus.awready) & (w_done | bus.wready)) w_next = W_B;
            W_B:     if (bus.bvalid) w_next = W_RESP;
            W_RESP:  w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_addr  <= '0;
            rd_size  <= '0;
            rd_owner <= OWNER_INST;
            rd_data  <= '0;
            wr_addr  <= '0;
            wr_size  <= '0;
            wr_strb  <= '0;
            wr_data  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (rd_start) begin
                rd_addr  <= inst_accept ? bus.inst_sram_addr : bus.data_sram_addr;
                rd_size  <= inst_accept ? bus.inst_sram_size : bus.data_sram_size;
                rd_owner <= inst_accept ? OWNER_INST : OWNER_DATA;
            end
            if (r_state == R_R && bus.rvalid)
                rd_data <= bus.rdata;
            if (wr_start) begin
                wr_addr <= bus.data_sram_addr;
                wr_size <= bus.data_sram_size;
                wr_strb <= bus.data_sram_wstrb;
                wr_data <= bus.data_sram_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (w_state == W_SEND) begin
                if (bus.awready) aw_done <= 1'b1;
                if (bus.wready)  w_done  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_busy <= 1'b0;
            data_busy <= 1'b0;
        end else begin
            if (inst_accept)
                inst_busy <= 1'b1;
            else if (r_state == R_RESP && rd_owner == OWNER_INST)
                inst_busy <= 1'b0;
            if (data_accept)
                data_busy <= 1'b1;
            else if ((r_state == R_RESP && rd_owner == OWNER_DATA) || w_state == W_RESP)
                data_busy <= 1'b0;
        end
    end

    assign bus.inst_sram_addr_ok      = inst_accept;
    assign bus.inst_sram_addr_ok_addr = inst_accept ? bus.inst_sram_addr : 32'd0;
    assign bus.inst_sram_data_ok      = (r_state == R_RESP) && (rd_owner == OWNER_INST);
    assign bus.inst_sram_rdata        = rd_data;
    assign bus.data_sram_addr_ok      = data_accept;
    assign bus.data_sram_data_ok      = ((r_state == R_RESP) && (rd_owner == OWNER_DATA))
                                      || (w_state == W_RESP);
    assign bus.data_sram_rdata        = rd_data;

    assign bus.arid    = axi_id(rd_owner);
    assign bus.araddr  = rd_addr;
    assign bus.arlen   = AXI_LEN;
    assign bus.arsize  = {1'b0, rd_size};
    assign bus.arburst = AXI_BURST;
    assign bus.arlock  = AXI_LOCK;
    assign bus.arcache = AXI_CACHE;
    assign bus.arprot  = AXI_PROT;
    assign bus.arvalid = (r_state == R_AR);
    assign bus.rready  = (r_state == R_R);

    assign bus.awid    = axi_id(OWNER_DATA);
    assign bus.awaddr  = wr_addr;
    assign bus.awlen   = AXI_LEN;
    assign bus.awsize  = {1'b0, wr_size};
    assign bus.awburst = AXI_BURST;
    assign bus.awlock  = AXI_LOCK;
    assign bus.awcache = AXI_CACHE;
    assign bus.awprot  = AXI_PROT;
    assign bus.awvalid = (w_state == W_SEND) && !aw_done;
    assign bus.wid     = axi_id(OWNER_DATA);
    assign bus.wdata   = wr_data;
    assign bus.wstrb   = wr_strb;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = (w_state == W_SEND) && !w_done;
    assign bus.bready  = (w_state == W_B);

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: stimulus pushes expected responses, a
// negedge monitor pops them whenever a data_ok pulse appears.
module tb_cpu_axi_bridge;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cpu_axi_bridge_if bus();

    cpu_axi_bridge dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    typedef struct {
        logic        port;
        logic        is_read;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic port, input logic is_read, input logic [31:0] d);
        exp_t e;
        e.port    = port;
        e.is_read = is_read;
        e.rdata   = d;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.inst_sram_req = 0; bus.inst_sram_wr = 0; bus.inst_sram_size = 0;
        bus.inst_sram_wstrb = 0; bus.inst_sram_addr = 0; bus.inst_sram_wdata = 0;
        bus.data_sram_req = 0; bus.data_sram_wr = 0; bus.data_sram_size = 0;
        bus.data_sram_wstrb = 0; bus.data_sram_addr = 0; bus.data_sram_wdata = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
        bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0;
        bus.bvalid = 0;
    endtask

    task automatic check_resp(input logic port, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_data_ok: got response on port %0d, required none", port);
        end else begin
            e = exp_q.pop_front();
            check("resp_port", {31'd0, port}, {31'd0, e.port});
            if (e.is_read) check("resp_rdata", d, e.rdata);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus.inst_sram_data_ok === 1'b1) check_resp(1'b0, bus.inst_sram_rdata);
            if (bus.data_sram_data_ok === 1'b1) check_resp(1'b1, bus.data_sram_rdata);
        end
    end

    // Called one cycle after a read accept; returns in the first cycle back in R_IDLE.
    task automatic read_slave(input logic [31:0] addr, input logic owner, input logic [1:0] size,
                              input int stall, input logic [31:0] data);
        for (int i = 0; i < stall; i++) begin
            bus.arready = 0;
            mid();
            check("stall_arvalid", {31'd0, bus.arvalid}, 32'd1);
            check("stall_araddr", bus.araddr, addr);
            check("stall_no_data_ok", {30'd0, bus.inst_sram_data_ok, bus.data_sram_data_ok}, 32'd0);
            step();
        end
        bus.arready = 1;
        mid();
        check("arvalid", {31'd0, bus.arvalid}, 32'd1);
        check("araddr", bus.araddr, addr);
        check("arid", {28'd0, bus.arid}, {31'd0, owner});
        check("arsize", {29'd0, bus.arsize}, {30'd0, size});
        check("arlen_arburst", {22'd0, bus.arlen, bus.arburst}, 32'h1);
        check("ar_rready_low", {31'd0, bus.rready}, 32'd0);
        check("ar_addr_ok_low", {30'd0, bus.inst_sram_addr_ok, bus.data_sram_addr_ok}, 32'd0);
        check("ar_addr_ok_addr", bus.inst_sram_addr_ok_addr, 32'd0);
        step();
        bus.arready = 0;
        bus.rvalid  = 1;
        bus.rdata   = data;
        mid();
        check("rready", {31'd0, bus.rready}, 32'd1);
        check("r_arvalid_low", {31'd0, bus.arvalid}, 32'd0);
        check("data_ok_not_comb", {30'd0, bus.inst_sram_data_ok, bus.data_sram_data_ok}, 32'd0);
        step();
        bus.rvalid = 0;
        bus.rdata  = 0;
        mid();
        check("data_ok_timing", {31'd0, owner ? bus.data_sram_data_ok : bus.inst_sram_data_ok}, 32'd1);
        check("resp_rready_low", {31'd0, bus.rready}, 32'd0);
        check("resp_addr_ok_low", {30'd0, bus.inst_sram_addr_ok, bus.data_sram_addr_ok}, 32'd0);
        step();
    endtask

    // Instruction fetch with wr/wstrb set to garbage: they must be ignored.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int stall);
        bus.inst_sram_req   = 1;
        bus.inst_sram_wr    = 1;
        bus.inst_sram_wstrb = 4'hF;
        bus.inst_sram_addr  = addr;
        bus.inst_sram_size  = 2'd2;
        mid();
        check("fetch_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        check("fetch_addr_ok_addr", bus.inst_sram_addr_ok_addr, addr);
        push(1'b0, 1'b1, data);
        step();
        bus.inst_sram_req  = 0;
        bus.inst_sram_wr   = 0;
        bus.inst_sram_addr = 32'h0;
        read_slave(addr, 1'b0, 2'd2, stall, data);
    endtask

    initial begin
        idle_inputs();
        bus.inst_sram_req = 1;
        #2;
        check("rst_addr_ok", {30'd0, bus.inst_sram_addr_ok, bus.data_sram_addr_ok}, 32'd0);
        check("rst_valids", {29'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 32'd0);
        check("rst_readys", {30'd0, bus.rready, bus.bready}, 32'd0);
        check("rst_data_ok", {30'd0, bus.inst_sram_data_ok, bus.data_sram_data_ok}, 32'd0);
        check("rst_rdata", bus.inst_sram_rdata, 32'd0);
        check("rst_addr_ok_addr", bus.inst_sram_addr_ok_addr, 32'd0);
        bus.inst_sram_req = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        step();

        // instruction fetch
        fetch(32'hBFC00000, 32'h3C1D0000, 0);

        // read arbitration: data read wins, fetch waits for R_IDLE
        bus.inst_sram_req  = 1;
        bus.inst_sram_addr = 32'hBFC00004;
        bus.inst_sram_size = 2'd2;
        bus.data_sram_req  = 1;
        bus.data_sram_wr   = 0;
        bus.data_sram_addr = 32'h80000010;
        bus.data_sram_size = 2'd2;
        mid();
        check("arb_data_addr_ok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
        check("arb_inst_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
        push(1'b1, 1'b1, 32'h12345678);
        step();
        bus.data_sram_req = 0;
        read_slave(32'h80000010, 1'b1, 2'd2, 0, 32'h12345678);
        mid();
        check("arb_inst_after", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        check("arb_inst_addr", bus.inst_sram_addr_ok_addr, 32'hBFC00004);
        push(1'b0, 1'b1, 32'h27BDFFF0);
        step();
        bus.inst_sram_req = 0;
        read_slave(32'hBFC00004, 1'b0, 2'd2, 0, 32'h27BDFFF0);

        // byte store, awready immediate, wready three cycles later
        bus.data_sram_req   = 1;
        bus.data_sram_wr    = 1;
        bus.data_sram_size  = 2'd0;
        bus.data_sram_wstrb = 4'b1000;
        bus.data_sram_addr  = 32'h80001003;
        bus.data_sram_wdata = 32'h11000000;
        mid();
        check("sb_addr_ok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
        push(1'b1, 1'b0, 32'h0);
        step();
        bus.data_sram_req = 0;
        bus.awready = 1;
        mid();
        check("sb_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        check("sb_awaddr", bus.awaddr, 32'h80001003);
        check("sb_awsize", {29'd0, bus.awsize}, 32'd0);
        check("sb_wstrb", {28'd0, bus.wstrb}, 32'h8);
        check("sb_wdata", bus.wdata, 32'h11000000);
        check("sb_ids_wlast", {23'd0, bus.awid, bus.wid, bus.wlast}, {23'd0, 4'd1, 4'd1, 1'b1});
        check("sb_bready_low", {31'd0, bus.bready}, 32'd0);
        step();
        bus.awready = 0;
        for (int i = 0; i < 2; i++) begin
            mid();
            check("sb_w_held", {30'd0, bus.awvalid, bus.wvalid}, 32'd1);
            check("sb_wait_bready", {31'd0, bus.bready}, 32'd0);
            step();
        end
        bus.wready = 1;
        mid();
        check("sb_w_hs", {30'd0, bus.awvalid, bus.wvalid}, 32'd1);
        step();
        bus.wready = 0;
        bus.bvalid = 1;
        mid();
        check("sb_bready", {31'd0, bus.bready}, 32'd1);
        check("sb_wvalid_low", {31'd0, bus.wvalid}, 32'd0);
        check("sb_no_early_ok", {31'd0, bus.data_sram_data_ok}, 32'd0);
        step();
        bus.bvalid = 0;
        mid();
        check("sb_data_ok", {31'd0, bus.data_sram_data_ok}, 32'd1);
        check("sb_bready_off", {31'd0, bus.bready}, 32'd0);
        step();

        // read after write to the same address
        bus.data_sram_req   = 1;
        bus.data_sram_wr    = 1;
        bus.data_sram_size  = 2'd2;
        bus.data_sram_wstrb = 4'hF;
        bus.data_sram_addr  = 32'h80002000;
        bus.data_sram_wdata = 32'hA5A5A5A5;
        mid();
        check("raw_w_addr_ok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
        push(1'b1, 1'b0, 32'h0);
        step();
        bus.data_sram_wr = 0;
        bus.awready = 1;
        bus.wready  = 1;
        mid();
        check("raw_send_blocked", {31'd0, bus.data_sram_addr_ok}, 32'd0);
        check("raw_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        step();
        bus.awready = 0;
        bus.wready  = 0;
        mid();
        check("raw_b_blocked", {31'd0, bus.data_sram_addr_ok}, 32'd0);
        check("raw_valids_off", {30'd0, bus.awvalid, bus.wvalid}, 32'd0);
        step();
        bus.bvalid = 1;
        mid();
        check("raw_b2_blocked", {31'd0, bus.data_sram_addr_ok}, 32'd0);
        step();
        bus.bvalid = 0;
        mid();
        check("raw_resp_blocked", {31'd0, bus.data_sram_addr_ok}, 32'd0);
        step();
        mid();
        check("raw_read_accept", {31'd0, bus.data_sram_addr_ok}, 32'd1);
        push(1'b1, 1'b1, 32'hDEADBEEF);
        step();
        bus.data_sram_req = 0;
        read_slave(32'h80002000, 1'b1, 2'd2, 0, 32'hDEADBEEF);

        // arready stall of five cycles
        fetch(32'hBFC00100, 32'h00000000, 5);

        // reset while the read FSM sits in R_R
        bus.inst_sram_req  = 1;
        bus.inst_sram_addr = 32'hBFC00200;
        bus.inst_sram_size = 2'd2;
        mid();
        check("mr_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
        push(1'b0, 1'b1, 32'h0);
        step();
        bus.inst_sram_req = 0;
        bus.arready = 1;
        step();
        bus.arready = 0;
        #1;
        check("mr_in_r", {31'd0, bus.rready}, 32'd1);
        resetn = 0;
        #1;
        check("mr_rready_off", {31'd0, bus.rready}, 32'd0);
        check("mr_arvalid_off", {31'd0, bus.arvalid}, 32'd0);
        check("mr_data_ok_off", {30'd0, bus.inst_sram_data_ok, bus.data_sram_data_ok}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        step();
        fetch(32'hBFC00000, 32'h3C1D0000, 0);

        repeat (2) step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the CPU core's two SRAM-like master ports (instruction and data: req / addr_ok / data_ok) into a single 32-bit AXI3 master. It sits directly downstream of the CPU core and upstream of the SoC AXI crossbar. It carries one read and one write transaction at a time and gives data reads priority over instruction fetch.

## Interface
- Parameters: none. Address and data are fixed at 32 bits; single-beat transfers only.
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- inst_sram_req / inst_sram_wr  in  1/1  instruction request; wr is ignored and the request is always treated as a read
- inst_sram_size / inst_sram_wstrb / inst_sram_addr / inst_sram_wdata  in  2/4/32/32  instruction request fields; wstrb and wdata are ignored
- inst_sram_addr_ok / inst_sram_addr_ok_addr  out  1/32  request accepted; echoes inst_sram_addr in the accept cycle, 0 otherwise
- inst_sram_data_ok / inst_sram_rdata  out  1/32  fetch response
- data_sram_req / data_sram_wr / data_sram_size / data_sram_wstrb  in  1/1/2/4  data request
- data_sram_addr / data_sram_wdata  in  32/32  data request address and write data
- data_sram_addr_ok / data_sram_data_ok / data_sram_rdata  out  1/1/32  data accept, response, read data
- arid / araddr / arlen / arsize / arburst / arlock / arcache / arprot  out  4/32/8/3/2/2/4/3  AXI read address fields
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rid / rdata / rresp / rlast / rvalid  in  4/32/2/1/1  AXI read data channel
- rready  out  1  read data ready
- awid / awaddr / awlen / awsize / awburst / awlock / awcache / awprot  out  same widths as ar*  AXI write address fields
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wid / wdata / wstrb / wlast / wvalid  out  4/32/4/1/1  AXI write data channel
- wready  in  1  write data ready
- bid / bresp / bvalid  in  4/2/1  AXI write response channel
- bready  out  1  write response ready

## Operation
- **Read FSM** has four states: R_IDLE → R_AR → R_R → R_RESP → R_IDLE.
- **Write FSM** has four states: W_IDLE → W_SEND → W_B → W_RESP → W_IDLE.
- **Busy flags:** inst_busy and data_busy are set on accept and cleared in the port's response cycle. At most one request per port is outstanding.
- **Accept rules** (addr_ok is combinational):
  - data_sram_addr_ok = data_sram_req & ~data_busy & W_IDLE & (data_sram_wr | R_IDLE).
  - inst_sram_addr_ok = inst_sram_req & ~inst_busy & R_IDLE & W_IDLE & ~(data_sram_req & ~data_sram_wr & ~data_busy).
  - Data reads therefore beat instruction reads. All reads are blocked while any write is in flight, which resolves read-after-write ordering.
- **On accept:** latch addr, size, owner (0 = inst, 1 = data), wstrb and wdata.
- **AXI field values:**
  - arid = awid = wid = {3'b0, owner}.
  - arsize = awsize = {1'b0, size}.
  - arlen = awlen = 0; arburst = awburst = 2'b01; lock, cache and prot = 0; wlast = 1.
- **Read path:**
  - R_AR drives arvalid = 1 and holds all ar* fields stable until arready.
  - R_R drives rready = 1. On rvalid, rdata is registered. rid and rresp are ignored; the response is routed by the latched owner.
  - R_RESP pulses the owner's data_ok for one cycle with the registered rdata.
- **Write path:**
  - W_SEND raises awvalid and wvalid together. Each drops independently on its own handshake; the FSM moves to W_B once both have completed, in either order or in the same cycle.
  - W_B drives bready = 1 and waits for bvalid.
  - W_RESP pulses data_sram_data_ok for one cycle. bresp is ignored.

## Timing
- **Reset values:** all valids, readys, data_ok and addr_ok are 0. rdata and addr_ok_addr are 0. Both FSMs are idle and both busy flags are clear.
- **Reset mid-transaction:** reset asserted at any time clears all outputs asynchronously and abandons the in-flight transaction.
- **Read latency:** accept in cycle 0 → arvalid in cycle 1. With arready in cycle 1 and rvalid in cycle 2, data_ok is asserted in cycle 3. Peak throughput is one read per 4 cycles.
- **Write latency:** accept in cycle 0 → awvalid and wvalid in cycle 1. With both readys in cycle 1 and bvalid in cycle 2, data_ok is asserted in cycle 3.
- **Response timing:** data_ok is never combinational from r or b; it always follows one cycle after the handshake.
- **Accept cycle:** the addr_ok cycle is itself the request handshake. The CPU may change req, addr and other fields in the following cycle.

## Structure
- A shared header holds the FSM state encodings, the owner constants and the AXI constant field values.
- The block is a single module with no sub-modules.

## Test plan
- **Inst fetch:** inst read of 0xBFC00000; arready asserted immediately; rvalid two cycles later with rdata 0x3C1D0000.
  - Required: addr_ok_addr = 0xBFC00000 in the accept cycle; arid = 0; arsize = 2; inst_data_ok with rdata 0x3C1D0000 one cycle after the r handshake.
- **Read arbitration:** inst read and data read of 0x80000010 requested in the same cycle.
  - Required: only data_addr_ok is asserted, with arid = 1. inst_addr_ok stays 0 until the read FSM returns to R_IDLE, then the fetch is accepted.
- **Byte store:** SB to 0x80001003 with size 0, wstrb 4'b1000, wdata 0x11000000; awready immediate, wready delayed 3 cycles.
  - Required: awvalid drops after 1 cycle while wvalid is held; bready is asserted only in W_B; data_ok follows bvalid by one cycle.
- **Read after write:** data write accepted, then a data read of the same address.
  - Required: the read's addr_ok stays 0 until the write FSM returns to W_IDLE.
- **arready stall:** arready held low for 5 cycles.
  - Required: arvalid and araddr are stable for all 5 cycles; no data_ok is issued.
- **Reset mid-read:** resetn driven low while the read FSM is in R_R.
  - Required: rready, data_ok and arvalid go to 0 immediately. After release, a fresh fetch completes normally.
